pll_loop_tuner: RTL and testbench
=================================

Name: pll_loop_tuner

Overview:
- Supervisor that drives the PLL's dynamic charge-pump and loop-filter inputs (icpsel, lpfres, lpfcap) and its reset, and consumes its lock output.
- Sweeps a candidate grid of loop settings, qualifies lock stability for each, holds the first good setting and re-acquires on loss of lock.
- Runs on the PLL reference clock, so it is independent of the PLL output; sits between board clock input and the PLL wrapper.

Parameters:
- ICP_MIN, 8, first icpsel candidate (6-bit value).
- ICP_MAX, 32, last icpsel candidate.
- ICP_STEP, 4, icpsel increment; must be >= 1.
- LPFRES_MIN, 1, first lpfres candidate (3-bit value).
- LPFRES_MAX, 4, last lpfres candidate.
- LPF_CAP, 0, constant lpfcap value (2-bit).
- RST_CYCLES, 50, PLL reset pulse width in clkin cycles.
- LOCK_TIMEOUT, 50000, max cycles from reset release to first synced lock.
- STABLE_CYCLES, 5000, consecutive synced-lock cycles required to qualify.
- LOSS_CYCLES, 8, consecutive synced-low cycles in LOCKED that count as loss.

Ports:
- clkin  in  1  reference clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- restart  in  1  single-cycle pulse: restart sweep from first candidate.
- pll_lock  in  1  PLL lock, asynchronous to clkin.
- pll_reset  out  1  PLL reset, active high.
- icpsel  out  6  charge-pump current select to PLL.
- lpfres  out  3  loop-filter resistor select.
- lpfcap  out  2  loop-filter capacitor select (= LPF_CAP).
- ready  out  1  PLL locked with a qualified setting.
- fail  out  1  all candidates exhausted.
- state_dbg  out  3  current FSM state encoding.

Behaviour:
- Reset values: pll_reset=1, icpsel=ICP_MIN, lpfres=LPFRES_MIN, lpfcap=LPF_CAP, ready=0, fail=0, state=RST_PLL, timer loaded with RST_CYCLES.
- pll_lock passes through a 2-flop synchronizer (lock_s); all decisions use lock_s (2-cycle latency).
- Settings change only in the cycle entering RST_PLL, so they are stable while pll_reset=1 and for the whole attempt.
- RST_PLL: pll_reset=1 for exactly RST_CYCLES cycles -> WAIT_LOCK, pll_reset=0, timer=LOCK_TIMEOUT.
- WAIT_LOCK: lock_s=1 -> CHECK_STABLE (count=1); timer expiry -> NEXT.
- CHECK_STABLE: lock_s=0 on any cycle -> NEXT; count reaches STABLE_CYCLES -> LOCKED, ready=1 the next cycle.
- LOCKED: ready=1, settings held. lock_s low for LOSS_CYCLES consecutive cycles -> RST_PLL with the same candidate, ready=0 next cycle. Shorter drops are ignored and the low-count clears on lock_s=1.
- NEXT (1 cycle): if icpsel+ICP_STEP <= ICP_MAX then icpsel += ICP_STEP.
  - Otherwise icpsel=ICP_MIN and lpfres+1, provided lpfres < LPFRES_MAX.
  - Then -> RST_PLL.
  - If both are at their max -> FAILED.
  - Compute the icpsel addition 7 bits wide so there is no wrap.
- FAILED: fail=1, pll_reset=1, settings hold the last candidate; remain until reset or restart.
- restart (any state): next cycle -> RST_PLL with first candidate; clears fail and ready. restart has priority over every other transition in the same cycle.
- Reset asserted mid-operation: immediate return to reset values on the next edge.

Optional Feature:
- Macro PLL_LOOP_TUNER_STATS_EN.
- Defined: adds outputs attempt_cnt[7:0] (RST_PLL entries since reset/restart, saturating at 255) and loss_cnt[7:0] (LOCKED loss events since reset, saturating; not cleared by restart).
- Undefined: ports and counters absent; all other behaviour is identical.

Decomposition:
- Package pll_loop_tuner_pkg: state enum (RST_PLL, WAIT_LOCK, CHECK_STABLE, LOCKED, NEXT, FAILED), width constants ICP_W=6, LPFRES_W=3, LPFCAP_W=2, TIMER_W=$clog2 of the max timing parameter.
- One sub-module, pll_lock_sync: 2-flop synchronizer with reset value 0.

Test Plan (sim params RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, LOSS_CYCLES=3, ICP 8..16 step 4, LPFRES 2..3):
1. PLL model locks 5 cycles after reset release for any setting -> pll_reset high 4 cycles, ready=1 with icpsel=8, lpfres=2, fail=0.
2. Model locks only for icpsel=16, lpfres=2 -> attempts 8, 12, 16 in order, ready=1 with icpsel=16; pll_reset re-pulsed 4 cycles per attempt.
3. Model never locks -> 6 attempts (icpsel 8,12,16 x lpfres 2,3), then fail=1, pll_reset=1, icpsel=16, lpfres=3; restart clears fail and tries icpsel=8, lpfres=2.
4. Lock high then 1-cycle drop during CHECK_STABLE -> advance to next candidate, ready stays 0.
5. In LOCKED: 2-cycle lock drop -> ready stays 1; 3-cycle drop -> ready=0, 4-cycle pll_reset with unchanged icpsel/lpfres, ready returns after requalification.
6. restart asserted in the same cycle LOCKED detects loss -> restart wins, first candidate loaded; reset asserted in WAIT_LOCK -> all outputs at reset values next edge.

Source files
------------

// File: rtl/pll_loop_tuner_pkg.sv
// pll_loop_tuner_pkg
//   Shared types and widths for the PLL loop tuner.
//   - state_t  : supervisor FSM states; the encoding is exported on state_dbg.
//   - ICP_W, LPFRES_W, LPFCAP_W : widths of the PLL dynamic loop inputs.
//   - TIMER_W  : width of the reset / lock-timeout / stability counters. It is
//                sized for the largest default timing parameter (LOCK_TIMEOUT).
//                Overrides larger than that need a wider TIMER_W.
package pll_loop_tuner_pkg;

  localparam int ICP_W    = 6;
  localparam int LPFRES_W = 3;
  localparam int LPFCAP_W = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Defaults: RST_CYCLES=50, LOCK_TIMEOUT=50000, STABLE_CYCLES=5000, LOSS_CYCLES=8
  localparam int TIMER_MAX = max_int(max_int(50, 50000), max_int(5000, 8));
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  typedef enum logic [2:0] {
    RST_PLL      = 3'd0,
    WAIT_LOCK    = 3'd1,
    CHECK_STABLE = 3'd2,
    LOCKED       = 3'd3,
    NEXT         = 3'd4,
    FAILED       = 3'd5
  } state_t;

endpackage

// File: rtl/pll_loop_tuner_lock_sync.sv
// pll_lock_sync
//   Two-flop synchronizer bringing the asynchronous PLL lock into the clkin
//   domain. Both flops clear to 0 so a stale lock never survives a reset.
//   Ports:
//     clkin    in  reference clock
//     reset    in  synchronous, active-high reset
//     pll_lock in  raw PLL lock (asynchronous)
//     lock_s   out synchronized lock, two clkin cycles of latency
module pll_lock_sync (
  input  logic clkin,
  input  logic reset,
  input  logic pll_lock,
  output logic lock_s
);

  logic lock_p0;

  always_ff @(posedge clkin) begin
    if (reset) begin
      lock_p0 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      lock_p0 <= pll_lock;
      lock_s  <= lock_p0;
    end
  end

endmodule

// File: rtl/pll_loop_tuner.sv
// pll_loop_tuner
//   Supervisor for a PLL with dynamic charge-pump / loop-filter inputs. It
//   sweeps icpsel (inner loop) and lpfres (outer loop) over a candidate grid,
//   pulses the PLL reset for each candidate, qualifies lock stability, holds
//   the first good setting and re-acquires with the same setting on loss of
//   lock. Runs entirely on clkin, independent of the PLL output clock.
//   Ports:
//     clkin      in  reference clock, rising edge
//     reset      in  synchronous, active-high reset
//     restart    in  one-cycle pulse: restart sweep from the first candidate
//     pll_lock   in  PLL lock (asynchronous)
//     pll_reset  out PLL reset, active high
//     icpsel     out charge-pump current select
//     lpfres     out loop-filter resistor select
//     lpfcap     out loop-filter capacitor select (constant LPF_CAP)
//     ready      out locked with a qualified setting
//     fail       out every candidate exhausted
//     state_dbg  out FSM state encoding
//   Optional (macro PLL_LOOP_TUNER_STATS_EN):
//     attempt_cnt out RST_PLL entries after reset/restart (retries and new
//                     candidates), saturating at 255; cleared by reset/restart
//     loss_cnt    out loss-of-lock events in LOCKED, saturating; reset only
module pll_loop_tuner
  import pll_loop_tuner_pkg::*;
#(
  parameter int ICP_MIN       = 8,
  parameter int ICP_MAX       = 32,
  parameter int ICP_STEP      = 4,
  parameter int LPFRES_MIN    = 1,
  parameter int LPFRES_MAX    = 4,
  parameter int LPF_CAP       = 0,
  parameter int RST_CYCLES    = 50,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 5000,
  parameter int LOSS_CYCLES   = 8
) (
  input  logic                clkin,
  input  logic                reset,
  input  logic                restart,
  input  logic                pll_lock,
  output logic                pll_reset,
  output logic [ICP_W-1:0]    icpsel,
  output logic [LPFRES_W-1:0] lpfres,
  output logic [LPFCAP_W-1:0] lpfcap,
  output logic                ready,
  output logic                fail,
  output logic [2:0]          state_dbg
`ifdef PLL_LOOP_TUNER_STATS_EN
  ,
  output logic [7:0]          attempt_cnt,
  output logic [7:0]          loss_cnt
`endif
);

  localparam logic [ICP_W-1:0]    ICP_FIRST  = ICP_W'(ICP_MIN);
  localparam logic [ICP_W:0]      ICP_STEP_X = (ICP_W+1)'(ICP_STEP);
  localparam logic [ICP_W:0]      ICP_LAST_X = (ICP_W+1)'(ICP_MAX);
  localparam logic [LPFRES_W-1:0] LPF_FIRST  = LPFRES_W'(LPFRES_MIN);
  localparam logic [LPFRES_W-1:0] LPF_LAST   = LPFRES_W'(LPFRES_MAX);
  localparam logic [LPFRES_W-1:0] LPF_ONE    = LPFRES_W'(1);
  localparam logic [TIMER_W-1:0]  ONE        = TIMER_W'(1);
  localparam logic [TIMER_W-1:0]  T_RST      = TIMER_W'(RST_CYCLES);
  localparam logic [TIMER_W-1:0]  T_LOCK     = TIMER_W'(LOCK_TIMEOUT);
  localparam logic [TIMER_W-1:0]  T_STABLE   = TIMER_W'(STABLE_CYCLES);
  localparam logic [TIMER_W-1:0]  T_LOSS_M1  = TIMER_W'(LOSS_CYCLES - 1);

  state_t               state;
  logic [TIMER_W-1:0]   timer;
  logic [TIMER_W-1:0]   run_cnt;   // stable-lock count in CHECK_STABLE, low-lock count in LOCKED
  logic                 lock_s;
  logic [ICP_W:0]       icp_sum;   // one bit wider so the step never wraps
  logic                 icp_step_ok;
  logic                 next_ok;
  logic                 loss_evt;

  pll_lock_sync u_sync (
    .clkin    (clkin),
    .reset    (reset),
    .pll_lock (pll_lock),
    .lock_s   (lock_s)
  );

  always_comb begin
    icp_sum     = {1'b0, icpsel} + ICP_STEP_X;
    icp_step_ok = (icp_sum <= ICP_LAST_X);
    next_ok     = icp_step_ok || (lpfres < LPF_LAST);
    loss_evt    = (state == LOCKED) && !lock_s && (run_cnt == T_LOSS_M1);
  end

  assign state_dbg = state;
  assign lpfcap    = LPFCAP_W'(LPF_CAP);

  // Settings (icpsel/lpfres) are only ever written on the edge that enters
  // RST_PLL, so they are stable through the whole reset pulse and attempt.
  always_ff @(posedge clkin) begin
    if (reset || restart) begin
      state     <= RST_PLL;
      timer     <= T_RST;
      run_cnt   <= '0;
      pll_reset <= 1'b1;
      icpsel    <= ICP_FIRST;
      lpfres    <= LPF_FIRST;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      unique case (state)
        RST_PLL: begin
          if (timer == ONE) begin
            state     <= WAIT_LOCK;
            pll_reset <= 1'b0;
            timer     <= T_LOCK;
          end else begin
            timer <= timer - ONE;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            run_cnt <= ONE;
            if (T_STABLE <= ONE) begin
              state   <= LOCKED;
              ready   <= 1'b1;
              run_cnt <= '0;
            end else begin
              state <= CHECK_STABLE;
            end
          end else if (timer == ONE) begin
            state <= NEXT;
          end else begin
            timer <= timer - ONE;
          end
        end
        CHECK_STABLE: begin
          if (!lock_s) begin
            state <= NEXT;
          end else if (run_cnt + ONE == T_STABLE) begin
            state   <= LOCKED;
            ready   <= 1'b1;
            run_cnt <= '0;
          end else begin
            run_cnt <= run_cnt + ONE;
          end
        end
        LOCKED: begin
          // Retry the same candidate; short drops only bump the low count.
          if (loss_evt) begin
            state     <= RST_PLL;
            pll_reset <= 1'b1;
            timer     <= T_RST;
            ready     <= 1'b0;
            run_cnt   <= '0;
          end else if (!lock_s) begin
            run_cnt <= run_cnt + ONE;
          end else begin
            run_cnt <= '0;
          end
        end
        NEXT: begin
          if (next_ok) begin
            state     <= RST_PLL;
            pll_reset <= 1'b1;
            timer     <= T_RST;
            if (icp_step_ok) begin
              icpsel <= icp_sum[ICP_W-1:0];
            end else begin
              icpsel <= ICP_FIRST;
              lpfres <= lpfres + LPF_ONE;
            end
          end else begin
            state     <= FAILED;
            fail      <= 1'b1;
            pll_reset <= 1'b1;
          end
        end
        FAILED: begin
          state <= FAILED;
        end
        default: begin
          state     <= RST_PLL;
          timer     <= T_RST;
          pll_reset <= 1'b1;
        end
      endcase
    end
  end

`ifdef PLL_LOOP_TUNER_STATS_EN
  // restart wins over a same-cycle loss, so such a loss is not counted.
  always_ff @(posedge clkin) begin
    if (reset) begin
      attempt_cnt <= '0;
      loss_cnt    <= '0;
    end else begin
      if (restart) begin
        attempt_cnt <= '0;
      end else if (((state == NEXT && next_ok) || loss_evt) && attempt_cnt != 8'hFF) begin
        attempt_cnt <= attempt_cnt + 8'd1;
      end
      if (!restart && loss_evt && loss_cnt != 8'hFF) begin
        loss_cnt <= loss_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pll_loop_tuner.sv
// tb_pll_loop_tuner
//   Directed and randomized bench for pll_loop_tuner with small timing
//   parameters. A behavioural PLL locks a programmable number of cycles after
//   reset release for settings marked good; a monitor records every completed
//   pll_reset pulse (settings, width, settings stability). Expected sweeps are
//   derived from the candidate grid with plain loops.
module tb_pll_loop_tuner;
  import pll_loop_tuner_pkg::*;

  localparam int ICP_MIN = 8, ICP_MAX = 16, ICP_STEP = 4;
  localparam int LPF_MIN = 2, LPF_MAX = 3, LPFCAP = 1;
  localparam int RSTC = 4, TMO = 20, STAB = 8, LOSS = 3;

  logic clkin = 1'b0, reset = 1'b1, restart = 1'b0, pll_lock = 1'b0;
  logic pll_reset, ready, fail;
  logic [5:0] icpsel;
  logic [2:0] lpfres, state_dbg;
  logic [1:0] lpfcap;
`ifdef PLL_LOOP_TUNER_STATS_EN
  logic [7:0] attempt_cnt, loss_cnt;
`endif

  pll_loop_tuner #(
    .ICP_MIN(ICP_MIN), .ICP_MAX(ICP_MAX), .ICP_STEP(ICP_STEP),
    .LPFRES_MIN(LPF_MIN), .LPFRES_MAX(LPF_MAX), .LPF_CAP(LPFCAP),
    .RST_CYCLES(RSTC), .LOCK_TIMEOUT(TMO), .STABLE_CYCLES(STAB), .LOSS_CYCLES(LOSS)
  ) dut (
    .clkin(clkin), .reset(reset), .restart(restart), .pll_lock(pll_lock),
    .pll_reset(pll_reset), .icpsel(icpsel), .lpfres(lpfres), .lpfcap(lpfcap),
    .ready(ready), .fail(fail), .state_dbg(state_dbg)
`ifdef PLL_LOOP_TUNER_STATS_EN
    , .attempt_cnt(attempt_cnt), .loss_cnt(loss_cnt)
`endif
  );

  always #5 clkin = ~clkin;

  int total = 0;
  int bad   = 0;

  // ---------------- behavioural PLL ----------------
  bit good_tbl [64][8];
  int lock_delay = 5;
  int drop_left  = 0;
  int since_rel  = 0;

  initial begin
    forever begin
      @(posedge clkin); #1;
      if (pll_reset) begin
        since_rel = 0;
        pll_lock  = 1'b0;
      end else begin
        since_rel++;
        if (drop_left > 0) begin
          drop_left--;
          pll_lock = 1'b0;
        end else begin
          pll_lock = good_tbl[icpsel][lpfres] && (since_rel >= lock_delay);
        end
      end
    end
  end

  // ---------------- pll_reset pulse monitor ----------------
  typedef struct {int icp; int lpf; int width; bit stable;} att_t;
  att_t atts[$];
  int   run = 0, st_icp = 0, st_lpf = 0;
  bit   prev_pr = 1'b1, unstable = 1'b0;

  initial begin
    att_t a;
    forever begin
      @(posedge clkin); #1;
      if (reset || restart) begin
        run = 0; unstable = 0; st_icp = icpsel; st_lpf = lpfres;
      end else begin
        if (!prev_pr && pll_reset) begin
          run = 0; unstable = 0; st_icp = icpsel; st_lpf = lpfres;
        end
        if (prev_pr) begin
          run++;
          if (icpsel != st_icp || lpfres != st_lpf) unstable = 1;
          if (!pll_reset) begin
            a.icp = st_icp; a.lpf = st_lpf; a.width = run; a.stable = !unstable;
            atts.push_back(a);
          end
        end
      end
      prev_pr = pll_reset;
    end
  end

  // ---------------- reference sweep model ----------------
  typedef struct {int icp; int lpf;} cand_t;
  cand_t exp_q[$];
  bit    exp_ok;

  task automatic build_expect();
    cand_t c;
    exp_q.delete();
    exp_ok = 0;
    for (int l = LPF_MIN; l <= LPF_MAX && !exp_ok; l++)
      for (int i = ICP_MIN; i <= ICP_MAX && !exp_ok; i += ICP_STEP) begin
        c.icp = i; c.lpf = l;
        exp_q.push_back(c);
        if (good_tbl[i][l]) exp_ok = 1;
      end
  endtask

  task automatic set_all(input bit v);
    for (int i = 0; i < 64; i++)
      for (int l = 0; l < 8; l++) good_tbl[i][l] = v;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_reset"}, pll_reset, 1);
    chk({tag, "_icpsel"}, icpsel, ICP_MIN);
    chk({tag, "_lpfres"}, lpfres, LPF_MIN);
    chk({tag, "_lpfcap"}, lpfcap, LPFCAP);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_state"}, state_dbg, int'(RST_PLL));
  endtask

  task automatic do_reset();
    @(negedge clkin); reset = 1'b1;
    repeat (2) @(negedge clkin);
    atts.delete();
    drop_left = 0;
    reset = 1'b0;
  endtask

  task automatic pulse_restart();
    @(negedge clkin); restart = 1'b1;
    @(negedge clkin); restart = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n = 0;
    while (!(ready || fail) && n < max_cyc) begin
      @(negedge clkin); n++;
    end
    chk({tag, "_done"}, int'(ready || fail), 1);
  endtask

  task automatic wait_state(input string tag, input int s, input int max_cyc);
    int n = 0;
    while (int'(state_dbg) != s && n < max_cyc) begin
      @(negedge clkin); n++;
    end
    chk({tag, "_reach_state"}, state_dbg, s);
  endtask

  task automatic run_sweep(input string tag);
    build_expect();
    wait_done(tag, 1000);
    chk({tag, "_n_attempts"}, atts.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < atts.size(); k++) begin
      chk($sformatf("%s_att%0d_icp", tag, k), atts[k].icp, exp_q[k].icp);
      chk($sformatf("%s_att%0d_lpf", tag, k), atts[k].lpf, exp_q[k].lpf);
      chk($sformatf("%s_att%0d_width", tag, k), atts[k].width, RSTC);
      chk($sformatf("%s_att%0d_stable", tag, k), atts[k].stable, 1);
    end
    chk({tag, "_ready"}, ready, exp_ok);
    chk({tag, "_fail"}, fail, !exp_ok);
    chk({tag, "_pll_reset"}, pll_reset, !exp_ok);
    chk({tag, "_icpsel"}, icpsel, exp_q[$].icp);
    chk({tag, "_lpfres"}, lpfres, exp_q[$].lpf);
    chk({tag, "_lpfcap"}, lpfcap, LPFCAP);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int n0;
    bit min_ready;

    set_all(0);
    repeat (3) @(negedge clkin);
    chk_reset_vals("rst");

    // 1: every setting locks -> first candidate qualifies
    set_all(1); lock_delay = 5;
    do_reset();
    run_sweep("t1");

    // 2: only icpsel=16, lpfres=2 locks
    set_all(0); good_tbl[16][2] = 1;
    do_reset();
    run_sweep("t2");

    // 3: nothing locks -> fail, hold, then restart
    set_all(0);
    do_reset();
    run_sweep("t3");
    repeat (20) @(negedge clkin);
    chk("t3_fail_hold", fail, 1);
    chk("t3_pll_reset_hold", pll_reset, 1);
    chk("t3_state_failed", state_dbg, int'(FAILED));
    atts.delete();
    pulse_restart();
    chk("t3r_fail", fail, 0);
    chk("t3r_icpsel", icpsel, ICP_MIN);
    chk("t3r_lpfres", lpfres, LPF_MIN);
    chk("t3r_pll_reset", pll_reset, 1);
    chk("t3r_state", state_dbg, int'(RST_PLL));
    begin
      int n = 0;
      while (atts.size() == 0 && n < 50) begin @(negedge clkin); n++; end
    end
    chk("t3r_attempt_seen", int'(atts.size() > 0), 1);
    if (atts.size() > 0) begin
      chk("t3r_att_icp", atts[0].icp, ICP_MIN);
      chk("t3r_att_lpf", atts[0].lpf, LPF_MIN);
      chk("t3r_att_width", atts[0].width, RSTC);
    end

    // 4: one-cycle drop during CHECK_STABLE -> move to next candidate
    set_all(1); lock_delay = 3;
    do_reset();
    wait_state("t4", int'(CHECK_STABLE), 100);
    @(posedge clkin); drop_left = 1;
    wait_done("t4", 500);
    chk("t4_n_attempts", atts.size(), 2);
    chk("t4_ready", ready, 1);
    chk("t4_icpsel", icpsel, ICP_MIN + ICP_STEP);
    chk("t4_lpfres", lpfres, LPF_MIN);

    // 5: short drop ignored, LOSS-cycle drop retries same candidate
    n0 = atts.size();
    @(posedge clkin); drop_left = LOSS - 1;
    min_ready = 1;
    repeat (10) begin
      @(negedge clkin);
      if (!ready) min_ready = 0;
    end
    chk("t5_short_drop_ready", min_ready, 1);
    chk("t5_short_drop_no_retry", atts.size(), n0);
    @(posedge clkin); drop_left = LOSS;
    repeat (5) @(negedge clkin);
    chk("t5_ready_before_loss", ready, 1);
    @(negedge clkin);
    chk("t5_ready_after_loss", ready, 0);
    chk("t5_pll_reset_after_loss", pll_reset, 1);
    chk("t5_icpsel_kept", icpsel, ICP_MIN + ICP_STEP);
    chk("t5_lpfres_kept", lpfres, LPF_MIN);
    wait_done("t5", 500);
    chk("t5_requalified", ready, 1);
    chk("t5_n_attempts", atts.size(), n0 + 1);
    if (atts.size() > n0) begin
      chk("t5_retry_icp", atts[n0].icp, ICP_MIN + ICP_STEP);
      chk("t5_retry_lpf", atts[n0].lpf, LPF_MIN);
      chk("t5_retry_width", atts[n0].width, RSTC);
    end

    // 6a: restart in the same cycle as loss detection -> restart wins
    @(posedge clkin); drop_left = LOSS;
    repeat (5) @(negedge clkin);
    restart = 1'b1;
    @(negedge clkin);
    restart = 1'b0;
    atts.delete();
    chk("t6a_icpsel", icpsel, ICP_MIN);
    chk("t6a_lpfres", lpfres, LPF_MIN);
    chk("t6a_ready", ready, 0);
    chk("t6a_fail", fail, 0);
    chk("t6a_pll_reset", pll_reset, 1);
    chk("t6a_state", state_dbg, int'(RST_PLL));
    wait_done("t6a", 500);
    chk("t6a_ready_first", ready, 1);
    chk("t6a_icpsel_first", icpsel, ICP_MIN);

    // 6b: reset asserted in WAIT_LOCK of a later candidate
    set_all(0);
    do_reset();
    begin
      int n = 0;
      while (!(atts.size() >= 2 && int'(state_dbg) == int'(WAIT_LOCK)) && n < 300) begin
        @(negedge clkin); n++;
      end
    end
    chk("t6b_in_wait_lock", state_dbg, int'(WAIT_LOCK));
    chk("t6b_later_icpsel", icpsel, ICP_MIN + ICP_STEP);
    reset = 1'b1;
    @(negedge clkin);
    chk_reset_vals("t6b");

    // random good-setting maps and lock delays
    for (int r = 0; r < 8; r++) begin
      set_all(0);
      for (int l = LPF_MIN; l <= LPF_MAX; l++)
        for (int i = ICP_MIN; i <= ICP_MAX; i += ICP_STEP)
          good_tbl[i][l] = ($urandom_range(0, 3) == 0);
      lock_delay = $urandom_range(1, 12);
      do_reset();
      run_sweep($sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
